mmio_console: RTL and testbench
===============================

Name: mmio_console

Overview:
- Memory-mapped byte console that acts as a responder on the core's data bus.
- Decodes loads and stores inside a 16-byte window.
- Buffers core-written bytes in a TX FIFO and drains them to an external valid/ready byte stream toward the Pocket bridge.
- Holds one received byte from the bridge for the core to read.
- Sits beside the data RAM; the top muxes bus_rdata into the load path when bus_hit=1.

Parameters:
- BASE_ADDR, 32'h1000_0000, window base; must be 16-byte aligned.
- DEPTH, 16, TX FIFO entries; power of two, ≥2, ≤128.

Ports:
- clk  in  1  clock
- reset_n  in  1  reset
- bus_addr  in  32  data-bus byte address (ALU result)
- bus_wdata  in  32  store data (rs2)
- bus_we  in  1  store this cycle
- bus_re  in  1  load this cycle
- bus_hit  out  1  bus_addr[31:4]==BASE_ADDR[31:4]
- bus_rdata  out  32  load data, combinational
- tx_valid  out  1  TX byte available
- tx_ready  in  1  sink accepts byte
- tx_data  out  8  TX byte (FIFO head)
- rx_valid  in  1  source offers byte
- rx_ready  out  1  RX holding register empty
- rx_data  in  8  RX byte

Behaviour:
- Reset is reset_n, asynchronous, active-low; clock is clk. All state is posedge clk.
- Reset values: FIFO empty (rd_ptr=wr_ptr=count=0); overflow=0; tx_en=1; rx_full=0, rx_byte=0.
- Outputs after reset: tx_valid=0, tx_data=0, rx_ready=1, bus_rdata=0 (when no hit), bus_hit per address.
- Register map (offset = bus_addr[3:2]; bus_addr[1:0] ignored):
  - 0 TXDATA: write pushes wdata[7:0]; read returns 0.
  - 1 STATUS, read: bit0 full (count==DEPTH), bit1 empty, bit2 overflow, bit3 rx_full, [15:8] count, other bits 0. Write with wdata[2]=1 clears overflow; other bits ignored.
  - 2 RXDATA, read: {23'b0, rx_full, rx_byte}. A read with rx_full=1 pops: rx_full←0 at the clock edge. Write has no effect.
  - 3 CTRL, read/write: bit0 tx_en; other bits read 0.
- Bus timing:
  - bus_rdata is combinational, same cycle as bus_re (single-cycle core, no wait states).
  - Write and pop side effects commit at the next posedge.
  - bus_hit=0 → bus_rdata=0 and no side effects.
  - bus_we and bus_re both high → write only; read side effects suppressed, bus_rdata still driven.
- TX FIFO:
  - Push = TXDATA write.
  - pop = tx_valid && tx_ready, where tx_valid = !empty && tx_en; tx_data = mem[rd_ptr], 0 when empty.
  - Push while full and no pop same cycle → byte dropped, overflow←1 (sticky), FIFO unchanged.
  - Push while full with pop same cycle → accepted, count unchanged.
  - Push and pop when neither full nor empty → count unchanged, both pointers advance.
  - Pointers wrap modulo DEPTH; count is log2(DEPTH)+1 bits wide.
  - tx_en=0 holds tx_valid low; FIFO content is retained and pushes still accepted.
  - tx_en cleared while tx_valid=1 and tx_ready=0: valid drops next cycle. This is the sole permitted valid retraction.
  - Otherwise tx_valid/tx_data are held stable until accepted.
- RX:
  - rx_ready = !rx_full.
  - rx_valid && rx_ready → rx_byte←rx_data, rx_full←1.
  - A core pop and a new accept cannot coincide, because ready=0 while full. The new byte becomes acceptable the cycle after the pop.
- Reset mid-transfer: FIFO and RX contents are discarded immediately and outputs return to reset values asynchronously.

Decomposition:
- rv32i package gets: CONSOLE_OFF_TXDATA/STATUS/RXDATA/CTRL constants (2-bit), STATUS bit-position constants, and a console_reg_e enum for the offset decode.
- One sub-module: sync_fifo (parameters WIDTH=8, DEPTH).
  - Ports: push, push_data, pop, head, full, empty, count.
  - Owns the pointers, wrap logic and simultaneous push/pop when full.
- mmio_console keeps decode, CSR-like registers, overflow and RX holding.

Test Plan:
- Reset, then read STATUS at BASE+4 → rdata=32'h0000_0002 (empty); tx_valid=0, rx_ready=1.
- Write 0x41,0x42,0x43 to BASE+0 with tx_ready=0 → STATUS count=3, tx_valid=1, tx_data=0x41. Raise tx_ready for 3 cycles → bytes 41,42,43 in order, then empty.
- tx_ready=0, DEPTH+1 writes → count=16, full=1, overflow=1, 17th byte absent on drain. Write BASE+4 with 0x4 → overflow=0.
- FIFO full; push 0x55 in the same cycle as a pop → count stays 16, 0x55 emerges last.
- rx_data=0x7E with rx_valid held → accepted one cycle, rx_ready=0. Read BASE+8 → 32'h0000_017E; next cycle rx_ready=1; re-read gives bit8=0.
- Write CTRL=0 with bytes queued → tx_valid=0. Write CTRL=1 → drains. Address BASE+16 → bus_hit=0, no effect. Assert reset_n=0 mid-drain → tx_valid=0 immediately.

Source files
------------

// File: rtl/mmio_console_pkg.sv
// Shared register-map constants and decode types for the MMIO byte console.
package mmio_console_pkg;

    localparam logic [1:0] CONSOLE_OFF_TXDATA = 2'd0;
    localparam logic [1:0] CONSOLE_OFF_STATUS = 2'd1;
    localparam logic [1:0] CONSOLE_OFF_RXDATA = 2'd2;
    localparam logic [1:0] CONSOLE_OFF_CTRL   = 2'd3;

    localparam int STATUS_FULL_BIT     = 0;
    localparam int STATUS_EMPTY_BIT    = 1;
    localparam int STATUS_OVERFLOW_BIT = 2;
    localparam int STATUS_RX_FULL_BIT  = 3;
    localparam int STATUS_COUNT_LSB    = 8;

    typedef enum logic [1:0] {
        REG_TXDATA = CONSOLE_OFF_TXDATA,
        REG_STATUS = CONSOLE_OFF_STATUS,
        REG_RXDATA = CONSOLE_OFF_RXDATA,
        REG_CTRL   = CONSOLE_OFF_CTRL
    } console_reg_e;

endpackage

// File: rtl/mmio_console_if.sv
// Core data-bus port plus the TX/RX byte streams toward the Pocket bridge.
interface mmio_console_if;
    logic [31:0] bus_addr;
    logic [31:0] bus_wdata;
    logic        bus_we;
    logic        bus_re;
    logic        bus_hit;
    logic [31:0] bus_rdata;
    logic        tx_valid;
    logic        tx_ready;
    logic [7:0]  tx_data;
    logic        rx_valid;
    logic        rx_ready;
    logic [7:0]  rx_data;

    modport slave (
        input  bus_addr, bus_wdata, bus_we, bus_re, tx_ready, rx_valid, rx_data,
        output bus_hit, bus_rdata, tx_valid, tx_data, rx_ready
    );

    modport master (
        output bus_addr, bus_wdata, bus_we, bus_re, tx_ready, rx_valid, rx_data,
        input  bus_hit, bus_rdata, tx_valid, tx_data, rx_ready
    );
endinterface

// File: rtl/mmio_console_sync_fifo.sv
// Single-clock FIFO; a push into a full FIFO is taken only when a pop frees a slot the same cycle.
module sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 16
) (
    input  logic                   clk,
    input  logic                   reset_n,
    input  logic                   push,
    input  logic [WIDTH-1:0]       push_data,
    input  logic                   pop,
    output logic [WIDTH-1:0]       head,
    output logic                   full,
    output logic                   empty,
    output logic [$clog2(DEPTH):0] count
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam logic [PTR_W:0] FULL_COUNT = (PTR_W + 1)'(DEPTH);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [PTR_W-1:0] r_rd_ptr;
    logic [PTR_W-1:0] r_wr_ptr;
    logic [PTR_W:0]   r_count;
    logic             w_do_push;
    logic             w_do_pop;

    assign full      = (r_count == FULL_COUNT);
    assign empty     = (r_count == '0);
    assign count     = r_count;
    assign w_do_pop  = pop && !empty;
    assign w_do_push = push && (!full || w_do_pop);
    assign head      = empty ? '0 : r_mem[r_rd_ptr];

    // NOTE: storage carries no reset; head is forced to zero while empty, so stale entries never show.
    always_ff @(posedge clk) begin
        if (w_do_push) r_mem[r_wr_ptr] <= push_data;
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_rd_ptr <= '0;
            r_wr_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_do_push) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_do_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
            case ({w_do_push, w_do_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end
endmodule

// File: rtl/mmio_console.sv
// Memory-mapped byte console: 16-byte register window, TX FIFO drain and a one-byte RX holding register.
module mmio_console
    import mmio_console_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR = 32'h1000_0000,
    parameter int          DEPTH     = 16
) (
    input  logic           clk,
    input  logic           reset_n,
    mmio_console_if.slave  bus
);
    localparam int CNT_W = $clog2(DEPTH) + 1;

    logic             w_hit;
    console_reg_e     w_reg;
    logic             w_wr;
    logic             w_rd;
    logic             w_push;
    logic             w_pop;
    logic             w_full;
    logic             w_empty;
    logic [CNT_W-1:0] w_count;
    logic [7:0]       w_head;
    logic [31:0]      w_status;
    logic [31:0]      w_rdata;
    logic             w_rx_pop;
    logic             w_rx_accept;
    logic             w_unused_bits;

    logic             r_overflow;
    logic             r_tx_en;
    logic             r_rx_full;
    logic [7:0]       r_rx_byte;

    assign w_hit  = (bus.bus_addr[31:4] == BASE_ADDR[31:4]);
    assign w_reg  = console_reg_e'(bus.bus_addr[3:2]);
    assign w_wr   = w_hit && bus.bus_we;
    // A store wins over a load in the same cycle: the read still returns data but has no side effect.
    assign w_rd   = w_hit && bus.bus_re && !bus.bus_we;

    assign w_push      = w_wr && (w_reg == REG_TXDATA);
    assign w_pop       = bus.tx_valid && bus.tx_ready;
    assign w_rx_pop    = w_rd && (w_reg == REG_RXDATA) && r_rx_full;
    assign w_rx_accept = bus.rx_valid && !r_rx_full;

    assign w_unused_bits = ^{bus.bus_addr[1:0], bus.bus_wdata[31:8]};

    sync_fifo #(.WIDTH(8), .DEPTH(DEPTH)) u_tx_fifo (
        .clk       (clk),
        .reset_n   (reset_n),
        .push      (w_push),
        .push_data (bus.bus_wdata[7:0]),
        .pop       (w_pop),
        .head      (w_head),
        .full      (w_full),
        .empty     (w_empty),
        .count     (w_count)
    );

    // NOTE: every combinational output gets a default first, so no path through the block infers a latch.
    always_comb begin
        w_status = '0;
        w_status[STATUS_FULL_BIT]                  = w_full;
        w_status[STATUS_EMPTY_BIT]                 = w_empty;
        w_status[STATUS_OVERFLOW_BIT]              = r_overflow;
        w_status[STATUS_RX_FULL_BIT]               = r_rx_full;
        w_status[STATUS_COUNT_LSB +: CNT_W]        = w_count;
    end

    always_comb begin
        w_rdata = '0;
        if (w_hit) begin
            case (w_reg)
                REG_STATUS: w_rdata = w_status;
                REG_RXDATA: w_rdata = {23'b0, r_rx_full, r_rx_byte};
                REG_CTRL:   w_rdata = {31'b0, r_tx_en};
                default:    w_rdata = '0;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_overflow <= 1'b0;
            r_tx_en    <= 1'b1;
            r_rx_full  <= 1'b0;
            r_rx_byte  <= '0;
        end else begin
            // Overflow is sticky: set by a dropped push, cleared only by a STATUS write with bit 2.
            if (w_push && w_full && !w_pop)
                r_overflow <= 1'b1;
            else if (w_wr && (w_reg == REG_STATUS) && bus.bus_wdata[STATUS_OVERFLOW_BIT])
                r_overflow <= 1'b0;

            if (w_wr && (w_reg == REG_CTRL)) r_tx_en <= bus.bus_wdata[0];

            if (w_rx_accept) begin
                r_rx_byte <= bus.rx_data;
                r_rx_full <= 1'b1;
            end else if (w_rx_pop) begin
                r_rx_full <= 1'b0;
            end
        end
    end

    assign bus.bus_hit   = w_hit;
    assign bus.bus_rdata = w_rdata;
    assign bus.tx_valid  = !w_empty && r_tx_en;
    assign bus.tx_data   = w_head;
    assign bus.rx_ready  = !r_rx_full;
endmodule

// File: tb/tb_mmio_console.sv
// Self-checking bench for mmio_console: register-map vector table, TX scoreboard and RX/CTRL/reset sequences.
module tb_mmio_console;
    localparam logic [31:0] BASE  = 32'h1000_0000;
    localparam int          DEPTH = 16;

    typedef struct {
        logic [31:0] addr;
        logic [31:0] wdata;
        logic        we;
        logic        re;
        logic        exp_hit;
        logic [31:0] exp_rdata;
    } vec_t;

    logic clk     = 1'b0;
    logic reset_n = 1'b0;
    always #5 clk = ~clk;

    mmio_console_if bus_if ();

    mmio_console #(.BASE_ADDR(BASE), .DEPTH(DEPTH)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus_if)
    );

    int         n_checks = 0;
    int         n_fail   = 0;
    logic [7:0] exp_q[$];
    logic       model_tx_en = 1'b1;
    int         tx_seen = 0;
    logic [7:0] last_tx = 8'h00;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Scoreboard: every accepted TX byte must match the oldest byte the model expects.
    always @(negedge clk) begin
        if (reset_n && bus_if.tx_valid && bus_if.tx_ready) begin
            if (exp_q.size() == 0) begin
                check("tx_unexpected_byte", {24'b0, bus_if.tx_data}, 32'h0000_0100);
            end else begin
                logic [7:0] e;
                e = exp_q.pop_front();
                last_tx = e;
                tx_seen++;
                check("tx_byte_order", {24'b0, bus_if.tx_data}, {24'b0, e});
            end
        end
    end

    task automatic align();
        @(posedge clk);
        #1;
    endtask

    task automatic bus_cycle(input logic [31:0] addr, input logic [31:0] wdata,
                             input logic we, input logic re,
                             output logic hit, output logic [31:0] rdata);
        bus_if.bus_addr  = addr;
        bus_if.bus_wdata = wdata;
        bus_if.bus_we    = we;
        bus_if.bus_re    = re;
        @(negedge clk);
        hit   = bus_if.bus_hit;
        rdata = bus_if.bus_rdata;
        align();
        bus_if.bus_we   = 1'b0;
        bus_if.bus_re   = 1'b0;
        bus_if.bus_addr = 32'h0;
    endtask

    task automatic wr(input logic [31:0] addr, input logic [31:0] data);
        logic        h;
        logic [31:0] r;
        if (addr[31:4] == BASE[31:4] && addr[3:2] == 2'd0) begin
            if (exp_q.size() < DEPTH || (model_tx_en && exp_q.size() > 0 && bus_if.tx_ready))
                exp_q.push_back(data[7:0]);
        end
        bus_cycle(addr, data, 1'b1, 1'b0, h, r);
        if (addr[31:4] == BASE[31:4] && addr[3:2] == 2'd3) model_tx_en = data[0];
    endtask

    task automatic rd(input logic [31:0] addr, input logic [31:0] exp, input string name);
        logic        h;
        logic [31:0] r;
        bus_cycle(addr, 32'h0, 1'b0, 1'b1, h, r);
        check(name, r, exp);
    endtask

    task automatic wait_drain(input string name, input int budget);
        for (int i = 0; i < budget && exp_q.size() != 0; i++) align();
        check({name, "_left"}, exp_q.size(), 0);
        @(negedge clk);
        check({name, "_valid_low"}, {31'b0, bus_if.tx_valid}, 32'h0);
        align();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    vec_t vecs[11];

    initial begin
        logic        h;
        logic [31:0] r;
        int          seen0;

        vecs[0]  = '{BASE + 32'd4,  32'h0,  1'b0, 1'b1, 1'b1, 32'h0000_0002};
        vecs[1]  = '{BASE + 32'd7,  32'h0,  1'b0, 1'b1, 1'b1, 32'h0000_0002};
        vecs[2]  = '{BASE + 32'd0,  32'h0,  1'b0, 1'b1, 1'b1, 32'h0000_0000};
        vecs[3]  = '{BASE + 32'd8,  32'h0,  1'b0, 1'b1, 1'b1, 32'h0000_0000};
        vecs[4]  = '{BASE + 32'd12, 32'h0,  1'b0, 1'b1, 1'b1, 32'h0000_0001};
        vecs[5]  = '{BASE + 32'd4,  32'h4,  1'b1, 1'b1, 1'b1, 32'h0000_0002};
        vecs[6]  = '{BASE + 32'd16, 32'h99, 1'b1, 1'b1, 1'b0, 32'h0000_0000};
        vecs[7]  = '{BASE + 32'd28, 32'h0,  1'b0, 1'b1, 1'b0, 32'h0000_0000};
        vecs[8]  = '{BASE - 32'd4,  32'h0,  1'b0, 1'b1, 1'b0, 32'h0000_0000};
        vecs[9]  = '{BASE + 32'd8,  32'hFF, 1'b1, 1'b1, 1'b1, 32'h0000_0000};
        vecs[10] = '{BASE + 32'd4,  32'h0,  1'b0, 1'b1, 1'b1, 32'h0000_0002};

        bus_if.bus_addr  = 32'h0;
        bus_if.bus_wdata = 32'h0;
        bus_if.bus_we    = 1'b0;
        bus_if.bus_re    = 1'b0;
        bus_if.tx_ready  = 1'b0;
        bus_if.rx_valid  = 1'b0;
        bus_if.rx_data   = 8'h00;
        repeat (2) @(posedge clk);
        @(negedge clk) reset_n = 1'b1;
        align();

        // Reset state of the streams
        @(negedge clk);
        check("reset_tx_valid", {31'b0, bus_if.tx_valid}, 32'h0);
        check("reset_tx_data",  {24'b0, bus_if.tx_data},  32'h0);
        check("reset_rx_ready", {31'b0, bus_if.rx_ready}, 32'h1);
        align();

        // Register-map vectors (no TX push, so state only changes where expected)
        for (int i = 0; i < 11; i++) begin
            bus_cycle(vecs[i].addr, vecs[i].wdata, vecs[i].we, vecs[i].re, h, r);
            check($sformatf("vec%0d_hit", i), {31'b0, h}, {31'b0, vecs[i].exp_hit});
            check($sformatf("vec%0d_rdata", i), r, vecs[i].exp_rdata);
        end

        // Three bytes queued with the sink stalled, then drained in order
        bus_if.tx_ready = 1'b0;
        wr(BASE, 32'h41);
        wr(BASE, 32'h42);
        wr(BASE, 32'h43);
        rd(BASE + 32'd4, 32'h0000_0300, "status_count3");
        @(negedge clk);
        check("abc_tx_valid", {31'b0, bus_if.tx_valid}, 32'h1);
        check("abc_tx_data",  {24'b0, bus_if.tx_data},  32'h41);
        align();
        seen0 = tx_seen;
        bus_if.tx_ready = 1'b1;
        wait_drain("drain_abc", 10);
        bus_if.tx_ready = 1'b0;
        check("drain_abc_count", tx_seen - seen0, 3);
        rd(BASE + 32'd4, 32'h0000_0002, "status_empty_after_abc");

        // DEPTH+1 pushes: last one dropped, overflow sticky until cleared
        for (int i = 0; i <= DEPTH; i++) wr(BASE, 32'h60 + i);
        rd(BASE + 32'd4, 32'h0000_1005, "status_full_overflow");
        wr(BASE + 32'd4, 32'h4);
        rd(BASE + 32'd4, 32'h0000_1001, "status_overflow_cleared");

        // Push while full with a pop in the same cycle
        seen0 = tx_seen;
        bus_if.tx_ready = 1'b1;
        wr(BASE, 32'h55);
        bus_if.tx_ready = 1'b0;
        rd(BASE + 32'd4, 32'h0000_1001, "status_full_push_pop");
        bus_if.tx_ready = 1'b1;
        wait_drain("drain_full", 40);
        bus_if.tx_ready = 1'b0;
        check("drain_full_count", tx_seen - seen0, DEPTH + 1);
        check("last_byte_55", {24'b0, last_tx}, 32'h55);

        // RX holding register
        bus_if.rx_valid = 1'b1;
        bus_if.rx_data  = 8'h7E;
        @(negedge clk);
        check("rx_ready_before", {31'b0, bus_if.rx_ready}, 32'h1);
        align();
        bus_if.rx_data = 8'h11;
        @(negedge clk);
        check("rx_ready_full", {31'b0, bus_if.rx_ready}, 32'h0);
        align();
        bus_if.rx_valid = 1'b0;
        rd(BASE + 32'd4, 32'h0000_000A, "status_rx_full");
        bus_cycle(BASE + 32'd8, 32'h0, 1'b1, 1'b1, h, r);
        check("rx_we_re_rdata", r, 32'h0000_017E);
        @(negedge clk);
        check("rx_we_re_no_pop", {31'b0, bus_if.rx_ready}, 32'h0);
        align();
        rd(BASE + 32'd8, 32'h0000_017E, "rx_pop_read");
        @(negedge clk);
        check("rx_ready_after_pop", {31'b0, bus_if.rx_ready}, 32'h1);
        align();
        rd(BASE + 32'd8, 32'h0000_007E, "rx_reread");

        // CTRL tx_en gating
        wr(BASE, 32'h31);
        wr(BASE, 32'h32);
        wr(BASE + 32'd12, 32'h0);
        @(negedge clk);
        check("ctrl_off_tx_valid", {31'b0, bus_if.tx_valid}, 32'h0);
        align();
        bus_if.tx_ready = 1'b1;
        repeat (3) align();
        check("ctrl_off_retained", exp_q.size(), 2);
        bus_if.tx_ready = 1'b0;
        rd(BASE + 32'd12, 32'h0, "ctrl_read_0");
        rd(BASE + 32'd4, 32'h0000_0200, "status_count2_gated");
        bus_if.tx_ready = 1'b1;
        wr(BASE + 32'd12, 32'hFFFF_FFFF);
        wait_drain("drain_ctrl", 10);
        bus_if.tx_ready = 1'b0;
        rd(BASE + 32'd12, 32'h1, "ctrl_read_1");

        // Reset asserted mid-drain with an RX byte held
        bus_if.rx_valid = 1'b1;
        bus_if.rx_data  = 8'h5A;
        align();
        bus_if.rx_valid = 1'b0;
        wr(BASE, 32'h81);
        wr(BASE, 32'h82);
        wr(BASE, 32'h83);
        bus_if.tx_ready = 1'b1;
        align();
        check("pre_reset_tx_valid", {31'b0, bus_if.tx_valid}, 32'h1);
        reset_n = 1'b0;
        #1;
        check("async_reset_tx_valid", {31'b0, bus_if.tx_valid}, 32'h0);
        check("async_reset_tx_data",  {24'b0, bus_if.tx_data},  32'h0);
        check("async_reset_rx_ready", {31'b0, bus_if.rx_ready}, 32'h1);
        exp_q.delete();
        model_tx_en = 1'b1;
        @(negedge clk) reset_n = 1'b1;
        align();
        bus_if.tx_ready = 1'b0;
        rd(BASE + 32'd4,  32'h0000_0002, "post_reset_status");
        rd(BASE + 32'd8,  32'h0000_0000, "post_reset_rxdata");
        rd(BASE + 32'd12, 32'h0000_0001, "post_reset_ctrl");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
